// File: rtl/mul_add_if.sv
// Handshake/operand bundle for the iterative multiply-accumulate: start/a/b/c in, busy/valid/p out.
// With MUL_ADD_OVF_EN defined the bundle also carries the ovf result flag.
interface mul_add_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] p;
`ifdef MUL_ADD_OVF_EN
  logic               ovf;

  modport master (output start, a, b, c, input busy, valid, p, ovf);
  modport slave  (input start, a, b, c, output busy, valid, p, ovf);
`else
  modport master (output start, a, b, c, input busy, valid, p);
  modport slave  (input start, a, b, c, output busy, valid, p);
`endif
endinterface

// File: rtl/mul_add.sv
// Iterative shift-and-add p = a*b + c; result and valid follow WIDTH steps after the start edge.
// start is accepted in any state and restarts the operation; MUL_ADD_OVF_EN adds the ovf flag.
module mul_add #(
  parameter int WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  mul_add_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   p_q;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            valid_q;
  logic            ovf_q;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.start) begin
      // Restart wins over an in-flight step; the old operation is simply dropped.
      state   <= RUN;
      acc     <= {{WIDTH{1'b0}}, bus.c};
      mcand   <= {{WIDTH{1'b0}}, bus.a};
      mplier  <= bus.b;
      cnt     <= CW'(WIDTH - 1);
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) begin
        state   <= IDLE;
        p_q     <= acc_next;
        valid_q <= 1'b1;
        ovf_q   <= (acc_next[PW-1:WIDTH] != '0);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.valid = valid_q;
  assign bus.p     = p_q;
`ifdef MUL_ADD_OVF_EN
  assign bus.ovf   = ovf_q;
`else
  // Flag is still tracked internally so both builds share one datapath.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_mul_add.sv
// Randomized and directed checks of mul_add (WIDTH=4) against an arithmetic a*b+c reference.
module tb_mul_add;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   last_p;
  int   last_ovf;

  mul_add_if #(.WIDTH(W)) bus ();

  mul_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input int exp);
`ifdef MUL_ADD_OVF_EN
    check(tag, 64'(bus.ovf), 64'(exp));
`else
    if (exp < 0) $display("unexpected ovf request %s", tag);
`endif
  endtask

  task automatic drive_junk();
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.c = W'($urandom);
  endtask

  // Pulse start with the operands; returns just after the loading edge (at a negedge).
  task automatic pulse_start(input int av, input int bv, input int cv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(av);
    bus.b = W'(bv);
    bus.c = W'(cv);
    @(negedge clk);
    bus.start = 1'b0;
    drive_junk();
  endtask

  // Observe the W busy cycles, then the completion; the reference is plain arithmetic.
  task automatic finish_op(input int av, input int bv, input int cv);
    int exp;
    exp = av * bv + cv;
    for (int k = 0; k < W; k++) begin
      check("busy_run", 64'(bus.busy), 64'd1);
      check("valid_run", 64'(bus.valid), 64'd0);
      check("p_stable_run", 64'(bus.p), 64'(last_p));
      check_ovf("ovf_run", 0);
      @(negedge clk);
    end
    check("busy_done", 64'(bus.busy), 64'd0);
    check("valid_done", 64'(bus.valid), 64'd1);
    check("p_result", 64'(bus.p), 64'(exp));
    check_ovf("ovf_result", (exp >= (1 << W)) ? 1 : 0);
    last_p   = exp;
    last_ovf = (exp >= (1 << W)) ? 1 : 0;
  endtask

  task automatic run_op(input int av, input int bv, input int cv);
    pulse_start(av, bv, cv);
    finish_op(av, bv, cv);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_p    = 0;
    last_ovf  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive_junk();

    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_p", 64'(bus.p), 64'd0);
    check_ovf("rst_ovf", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, maximum and zero-operand cases.
    run_op(3, 4, 2);
    run_op(15, 15, 15);
    run_op(0, 9, 7);
    run_op(9, 0, 0);

    // Restart after two busy cycles: the first operation must never complete.
    pulse_start(2, 2, 0);
    check("rs_busy0", 64'(bus.busy), 64'd1);
    check("rs_valid0", 64'(bus.valid), 64'd0);
    @(negedge clk);
    check("rs_busy1", 64'(bus.busy), 64'd1);
    check("rs_valid1", 64'(bus.valid), 64'd0);
    run_op(5, 3, 1);

    // Asynchronous reset in the middle of an operation.
    pulse_start(7, 7, 0);
    check("mr_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy_async", 64'(bus.busy), 64'd0);
    check("mr_valid_async", 64'(bus.valid), 64'd0);
    check("mr_p_async", 64'(bus.p), 64'd0);
    check_ovf("mr_ovf_async", 0);
    last_p = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 1; k++) begin
      @(negedge clk);
      check("mr_no_valid", 64'(bus.valid), 64'd0);
    end
    run_op(1, 1, 1);

    // Result holds while idle with random operand noise.
    run_op(3, 4, 2);
    for (int k = 0; k < 10; k++) begin
      drive_junk();
      @(negedge clk);
      check("hold_valid", 64'(bus.valid), 64'd1);
      check("hold_p", 64'(bus.p), 64'd14);
    end
    pulse_start(6, 5, 4);
    check("hold_clr_valid", 64'(bus.valid), 64'd0);
    check("hold_clr_busy", 64'(bus.busy), 64'd1);
    finish_op(6, 5, 4);

    // start held as a level keeps reloading and never completes.
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_junk();
      @(negedge clk);
      check("lvl_busy", 64'(bus.busy), 64'd1);
      check("lvl_valid", 64'(bus.valid), 64'd0);
    end
    bus.start = 1'b0;
    for (int k = 0; k < W; k++) @(negedge clk);
    last_p = int'(bus.p);

    // Randomized operations, some interrupted by a restart.
    for (int n = 0; n < 40; n++) begin
      int av, bv, cv, cut;
      av  = int'($urandom_range(0, (1 << W) - 1));
      bv  = int'($urandom_range(0, (1 << W) - 1));
      cv  = int'($urandom_range(0, (1 << W) - 1));
      cut = int'($urandom_range(0, 3));
      if (cut == 0) begin
        pulse_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
        for (int k = 0; k < W - 1; k++) begin
          check("rnd_cut_valid", 64'(bus.valid), 64'd0);
          @(negedge clk);
        end
        bus.start = 1'b1;
        bus.a = W'(av);
        bus.b = W'(bv);
        bus.c = W'(cv);
        @(negedge clk);
        bus.start = 1'b0;
        drive_junk();
        finish_op(av, bv, cv);
      end else begin
        run_op(av, bv, cv);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
